// File: rtl/mm_pkg.sv
// mm_pkg: shared widths, loader state encoding and operand memory select values
// for the matrix stream loader and its neighbours.
package mm_pkg;
    localparam int DATA_W = 8;
    localparam int MAX_N  = 4;
    localparam int ADDR_W = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_GET_A, ST_GET_B, ST_HANDOFF} state_t;
    localparam logic MEM_SEL_A = 1'b0;
    localparam logic MEM_SEL_B = 1'b1;
endpackage

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: parses size byte + row-major A and B bytes into operand memories, then starts the multiplier.
// Optional inter-byte timeout is built only when LOADER_TIMEOUT_EN is defined.
module matrix_stream_loader
    import mm_pkg::*;
#(
    parameter int DATA_W      = mm_pkg::DATA_W,
    parameter int MAX_N       = mm_pkg::MAX_N,
    parameter int ADDR_W      = mm_pkg::ADDR_W,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        dim,
    output logic              mm_start,
    input  logic              mm_ack,
    output logic              busy,
    output logic              err
);
    localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    state_t            state, state_d;
    logic [IDX_W-1:0]  row, col, row_d, col_d, last_idx;
    logic [2:0]        dim_d;
    logic              we_d, sel_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              in_get, size_ok, col_last, row_last, tmo_hit;

    assign last_idx = IDX_W'(dim - 3'd1);
    assign col_last = col == last_idx;
    assign row_last = row == last_idx;
    assign size_ok  = rx_data != '0 && rx_data <= DATA_W'(MAX_N);
    assign in_get   = state == ST_GET_A || state == ST_GET_B;
    assign busy     = state != ST_IDLE;
    assign mm_start = state == ST_HANDOFF;

`ifdef LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            tmo_cnt <= '0;
        else
            tmo_cnt <= (in_get && !rx_valid) ? tmo_cnt + 1'b1 : '0;
    assign tmo_hit = in_get && !rx_valid && tmo_cnt == TMO_W'(TIMEOUT_CYC - 1);
`else
    // Without the counter the FSM waits forever; the expression is constant false.
    assign tmo_hit = TIMEOUT_CYC < 0;
`endif

    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        dim_d   = dim;
        we_d    = 1'b0;
        err_d   = 1'b0;
        sel_d   = mem_sel;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        case (state)
            ST_IDLE: if (rx_valid) begin
                if (size_ok) begin
                    dim_d   = rx_data[2:0];
                    row_d   = '0;
                    col_d   = '0;
                    state_d = ST_GET_A;
                end else
                    err_d = 1'b1;
            end
            ST_GET_A, ST_GET_B: if (rx_valid) begin
                we_d    = 1'b1;
                sel_d   = (state == ST_GET_B) ? MEM_SEL_B : MEM_SEL_A;
                addr_d  = ADDR_W'(row) * ADDR_W'(MAX_N) + ADDR_W'(col);
                wdata_d = rx_data;
                col_d   = col_last ? '0 : col + 1'b1;
                row_d   = col_last ? (row_last ? '0 : row + 1'b1) : row;
                if (col_last && row_last)
                    state_d = (state == ST_GET_A) ? ST_GET_B : ST_HANDOFF;
            end else if (tmo_hit) begin
                err_d   = 1'b1;
                row_d   = '0;
                col_d   = '0;
                state_d = ST_IDLE;
            end
            ST_HANDOFF: begin
                err_d   = rx_valid;
                state_d = mm_ack ? ST_IDLE : ST_HANDOFF;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            row       <= '0;
            col       <= '0;
            dim       <= '0;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            row       <= row_d;
            col       <= col_d;
            dim       <= dim_d;
            mem_we    <= we_d;
            mem_sel   <= sel_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            err       <= err_d;
        end
    end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: table-driven A/B load vectors plus directed handoff, error, reset and timeout sequences.
module tb_matrix_stream_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       mem_we, mem_sel;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [2:0] dim;
    logic       mm_start, mm_ack, busy, err;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int we_cnt = 0;
    int e0, w0;

    typedef struct {
        logic [7:0] d;
        logic       sel;
        logic [3:0] addr;
    } vec_t;
    vec_t v[18];
    logic [7:0] a_bytes[9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h04, 8'h04, 8'h03, 8'h04};
    logic [7:0] b_bytes[9] = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h07, 8'h08, 8'h08, 8'h07, 8'h08};
    logic [3:0] addrs[9]   = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10};

    matrix_stream_loader #(.TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .dim(dim), .mm_start(mm_start), .mm_ack(mm_ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err) err_cnt++;
        if (mem_we) we_cnt++;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return {12'd0, mem_we, mem_sel, mem_addr, mem_wdata, dim, mm_start, busy, err};
    endfunction

    initial begin
        rst = 1'b0; rx_valid = 1'b0; rx_data = '0; mm_ack = 1'b0;
        for (int i = 0; i < 9; i++) begin
            v[i]     = '{d: a_bytes[i], sel: 1'b0, addr: addrs[i]};
            v[i + 9] = '{d: b_bytes[i], sel: 1'b1, addr: addrs[i]};
        end
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b1;

        send(8'd3);
        chk("size3_busy", busy, 1);
        chk("size3_dim", dim, 3);
        chk("size3_no_write", mem_we, 0);
        for (int i = 0; i < 18; i++) begin
            send(v[i].d);
            chk($sformatf("wr%0d_we", i), mem_we, 1);
            chk($sformatf("wr%0d_sel", i), mem_sel, v[i].sel);
            chk($sformatf("wr%0d_addr", i), mem_addr, v[i].addr);
            chk($sformatf("wr%0d_data", i), mem_wdata, v[i].d);
            @(negedge clk);
            chk($sformatf("wr%0d_single", i), mem_we, 0);
        end
        chk("handoff_start", mm_start, 1);
        repeat (5) begin
            @(negedge clk);
            chk("ack_wait_start", mm_start, 1);
        end
        mm_ack = 1'b1;
        @(negedge clk);
        mm_ack = 1'b0;
        chk("ack_start_drop", mm_start, 0);
        chk("ack_idle", busy, 0);

        #1 e0 = err_cnt; w0 = we_cnt;
        send(8'd0);
        chk("size0_err", err, 1);
        chk("size0_busy", busy, 0);
        send(8'd5);
        chk("size5_err", err, 1);
        chk("size5_busy", busy, 0);
        chk("bad_size_dim", dim, 3);
        @(negedge clk);
        #1;
        chk("bad_size_err_pulses", err_cnt - e0, 2);
        chk("bad_size_no_write", we_cnt - w0, 0);

        send(8'd2);
        send(8'h11);
        send(8'h22);
        chk("pre_rst_we", mem_we, 1);
        #2 rst = 1'b0;
        #1 chk("async_rst_outputs", outs(), 0);
        @(negedge clk);
        rst = 1'b1;
        send(8'd1);
        chk("n1_dim", dim, 1);
        send(8'h0A);
        chk("n1_a_we", mem_we, 1);
        chk("n1_a_sel", mem_sel, 0);
        chk("n1_a_addr", mem_addr, 0);
        chk("n1_a_data", mem_wdata, 8'h0A);
        send(8'h0B);
        chk("n1_b_we", mem_we, 1);
        chk("n1_b_sel", mem_sel, 1);
        chk("n1_b_addr", mem_addr, 0);
        chk("n1_b_data", mem_wdata, 8'h0B);
        chk("n1_start", mm_start, 1);

        #1 w0 = we_cnt;
        send(8'h55);
        chk("handoff_byte_err", err, 1);
        chk("handoff_byte_no_we", mem_we, 0);
        chk("handoff_byte_start", mm_start, 1);
        #1 chk("handoff_byte_no_write", we_cnt - w0, 0);
        mm_ack = 1'b1;
        @(negedge clk);
        mm_ack = 1'b0;
        chk("handoff_byte_ack", mm_start, 0);

        mm_ack = 1'b1;
        send(8'd1);
        chk("ack_ignored_get", busy, 1);
        send(8'h77);
        chk("ack_ignored_write", mem_we, 1);
        send(8'h88);
        chk("entry_start", mm_start, 1);
        chk("entry_data", mem_wdata, 8'h88);
        @(negedge clk);
        chk("entry_ack_start", mm_start, 0);
        chk("entry_ack_idle", busy, 0);
        mm_ack = 1'b0;

`ifdef LOADER_TIMEOUT_EN
        #1 e0 = err_cnt;
        send(8'd2);
        send(8'h31);
        repeat (99) @(negedge clk);
        #1;
        chk("tmo_not_early", err_cnt - e0, 0);
        chk("tmo_busy_before", busy, 1);
        @(negedge clk);
        chk("tmo_err", err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_start", mm_start, 0);
        #1 e0 = err_cnt;
        send(8'd2);
        for (int k = 0; k < 4; k++) begin
            repeat (97) @(negedge clk);
            send(8'h40 + 8'(k));
        end
        #1;
        chk("tmo_spaced_no_err", err_cnt - e0, 0);
        chk("tmo_spaced_busy", busy, 1);
        for (int k = 0; k < 4; k++) send(8'h50 + 8'(k));
        chk("tmo_spaced_start", mm_start, 1);
`else
        #1 e0 = err_cnt;
        send(8'd2);
        send(8'h31);
        repeat (300) @(negedge clk);
        #1;
        chk("no_tmo_err", err_cnt - e0, 0);
        chk("no_tmo_busy", busy, 1);
        for (int k = 0; k < 7; k++) send(8'h40 + 8'(k));
        chk("no_tmo_start", mm_start, 1);
`endif
        mm_ack = 1'b1;
        @(negedge clk);
        mm_ack = 1'b0;
        chk("final_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
